if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Feeds the decode stage directly (Instruction, PC).

---
 rtl/riscv_pipe_pkg.sv | 23 ++
 rtl/adder.sv | 22 ++
 rtl/if_id_reg.sv | 57 +++++
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared constants and types for the pipeline front end.
//   XLEN_PC    width of instruction addresses (byte addressed)
//   RESET_PC   first address fetched after reset
//   NOP_INSTR  bubble instruction (addi x0,x0,0)
//   if_state_e fetch-stage sequencing state
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int XLEN_PC = 12;

    localparam logic [XLEN_PC-1:0] RESET_PC  = 12'h000;
    localparam logic [31:0]        NOP_INSTR = 32'h00000013;

    // BOOT issues the very first address while the IF/ID register still
    // holds a bubble; RUN is the steady-state fetch loop.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_e;

endpackage

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// Adder
// Plain ripple-style WIDTH-bit adder with carry in/out; sum is modulo 2^WIDTH.
// Ports:
//   a, b  in   WIDTH  operands
//   cin   in   1      carry in
//   sum   out  WIDTH  a + b + cin (low WIDTH bits)
//   cout  out  1      carry out
// ---------------------------------------------------------------------------
module Adder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with hold and bubble-insert controls, plus the
// counter of real instructions handed to decode.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   hold       in   1   keep current contents (stall)
//   flush      in   1   load a bubble instead of instr_in
//   instr_in   in   32  instruction arriving from memory
//   pc_in      in   12  address of instr_in (also tags bubbles)
//   instr      out  32  registered instruction
//   pc         out  12  registered address
//   valid      out  1   register holds a real instruction
//   fetch_cnt  out  16  number of real instructions loaded (wraps)
// Priority: rst > hold > flush > load.
// ---------------------------------------------------------------------------
module if_id_reg
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] NOP = riscv_pipe_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic [31:0]        instr_in,
    input  logic [XLEN_PC-1:0] pc_in,
    output logic [31:0]        instr,
    output logic [XLEN_PC-1:0] pc,
    output logic               valid,
    output logic [15:0]        fetch_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr     <= NOP;
            pc        <= '0;
            valid     <= 1'b0;
            fetch_cnt <= '0;
        end else if (!hold) begin
            if (flush) begin
                // Bubble keeps the address of the discarded slot so the
                // PC seen by decode stays meaningful for debug.
                instr <= NOP;
                pc    <= pc_in;
                valid <= 1'b0;
            end else begin
                instr     <= instr_in;
                pc        <= pc_in;
                valid     <= 1'b1;
                fetch_cnt <= fetch_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage plus IF/ID register. Drives a synchronous-read
// instruction memory (data returns one cycle after the address) and handles
// hazard stalls and decode-resolved branch redirects.
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   imem_addr    out  12  byte address issued to instruction memory
//   imem_rdata   in   32  data for the address issued last cycle
//   Stall        in   1   hold PC and IF/ID register
//   Branch       in   1   decode holds a branch
//   Equal        in   1   branch operands compare equal
//   BranchAddr   in   12  branch target
//   Instruction  out  32  IF/ID instruction
//   PC           out  12  IF/ID instruction address
//   if_valid     out  1   IF/ID holds a real instruction
//   fetch_cnt    out  16  real instructions delivered to decode
// ---------------------------------------------------------------------------
module if_stage
    import riscv_pipe_pkg::*;
#(
    parameter logic [XLEN_PC-1:0] RESET_PC  = riscv_pipe_pkg::RESET_PC,
    parameter logic [31:0]        NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN_PC-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               Stall,
    input  logic               Branch,
    input  logic               Equal,
    input  logic [XLEN_PC-1:0] BranchAddr,
    output logic [31:0]        Instruction,
    output logic [XLEN_PC-1:0] PC,
    output logic               if_valid,
    output logic [15:0]        fetch_cnt
);

    localparam logic [XLEN_PC-1:0] FOUR = 12'd4;

    if_state_e          state_q, state_d;
    // pc_q: next address to issue; f_pc_q: address whose data is on
    // imem_rdata this cycle.
    logic [XLEN_PC-1:0] pc_q, pc_d;
    logic [XLEN_PC-1:0] f_pc_q, f_pc_d;
    logic [XLEN_PC-1:0] pc_plus4;
    logic [XLEN_PC-1:0] br_plus4;
    logic               unused_pc_carry;
    logic               unused_br_carry;
    logic               taken;
    logic               hold;
    logic               flush;

    assign taken = Branch & Equal;

    Adder #(.WIDTH(XLEN_PC)) u_pc_inc (
        .a    (pc_q),
        .b    (FOUR),
        .cin  (1'b0),
        .sum  (pc_plus4),
        .cout (unused_pc_carry)
    );

    // Fetch after a redirect continues from the target, so the target+4
    // is needed in the same cycle the target itself is issued.
    Adder #(.WIDTH(XLEN_PC)) u_br_inc (
        .a    (BranchAddr),
        .b    (FOUR),
        .cin  (1'b0),
        .sum  (br_plus4),
        .cout (unused_br_carry)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        f_pc_d    = f_pc_q;
        imem_addr = pc_q;
        hold      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            BOOT: begin
                // No data is in flight yet, so IF/ID gets a bubble and
                // Stall is ignored.
                f_pc_d  = pc_q;
                pc_d    = pc_plus4;
                flush   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (Stall) begin
                    // Re-read the in-flight address so the same data is
                    // presented again when the stall lifts.
                    imem_addr = f_pc_q;
                    hold      = 1'b1;
                end else if (taken) begin
                    imem_addr = BranchAddr;
                    f_pc_d    = BranchAddr;
                    pc_d      = br_plus4;
                    flush     = 1'b1;
                end else begin
                    f_pc_d = pc_q;
                    pc_d   = pc_plus4;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            f_pc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            f_pc_q  <= f_pc_d;
        end
    end

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .flush     (flush),
        .instr_in  (imem_rdata),
        .pc_in     (f_pc_q),
        .instr     (Instruction),
        .pc        (PC),
        .valid     (if_valid),
        .fetch_cnt (fetch_cnt)
    );

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Instruction memory returns address-tagged
// words one cycle after the address, so every delivered instruction can be
// predicted from its PC. Inputs are driven on the falling edge and outputs
// sampled 1ns later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Equal = 1'b0;
    logic [11:0] BranchAddr = 12'h000;
    logic [31:0] Instruction;
    logic [11:0] PC;
    logic        if_valid;
    logic [15:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        branch;
        logic        equal;
        logic [11:0] baddr;
        logic [11:0] exp_addr;
        logic [11:0] exp_pc;
        logic        exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[23];

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Stall       (Stall),
        .Branch      (Branch),
        .Equal       (Equal),
        .BranchAddr  (BranchAddr),
        .Instruction (Instruction),
        .PC          (PC),
        .if_valid    (if_valid),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tagOf(input logic [11:0] a);
        return {20'hC0DE5, a};
    endfunction

    always @(posedge clk) imem_rdata <= tagOf(imem_addr);

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] exp_addr,
                               input logic [11:0] exp_pc, input logic exp_valid,
                               input logic [15:0] exp_cnt);
        logic [31:0] exp_instr;
        exp_instr = exp_valid ? tagOf(exp_pc) : NOP;
        checkField({tag, " imem_addr"}, {20'h0, imem_addr}, {20'h0, exp_addr});
        checkField({tag, " Instruction"}, Instruction, exp_instr);
        checkField({tag, " PC"}, {20'h0, PC}, {20'h0, exp_pc});
        checkField({tag, " if_valid"}, {31'h0, if_valid}, {31'h0, exp_valid});
        checkField({tag, " fetch_cnt"}, {16'h0, fetch_cnt}, {16'h0, exp_cnt});
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic e, input logic [11:0] ba);
        @(negedge clk);
        rst        = 1'b0;
        Stall      = s;
        Branch     = b;
        Equal      = e;
        BranchAddr = ba;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b1;
        Stall  = 1'b0;
        Branch = 1'b0;
        Equal  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        //            stall br eq baddr   addr    pc      v  cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 12'h000, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h008, 12'h000, 1'b1, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h00C, 12'h004, 1'b1, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h010, 12'h008, 1'b1, 16'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h014, 12'h00C, 1'b1, 16'd4};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h014, 12'h010, 1'b1, 16'd5};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 12'h200, 12'h014, 12'h010, 1'b1, 16'd5};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h014, 12'h010, 1'b1, 16'd5};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h018, 12'h010, 1'b1, 16'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h01C, 12'h014, 1'b1, 16'd6};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h020, 12'h018, 1'b1, 16'd7};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 12'h300, 12'h024, 12'h01C, 1'b1, 16'd8};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 12'h100, 12'h100, 12'h020, 1'b1, 16'd9};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h104, 12'h024, 1'b0, 16'd9};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h108, 12'h100, 1'b1, 16'd10};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 12'hFF0, 12'hFF0, 12'h104, 1'b1, 16'd11};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'hFF4, 12'h108, 1'b0, 16'd11};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'hFF8, 12'hFF0, 1'b1, 16'd12};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'hFFC, 12'hFF4, 1'b1, 16'd13};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'hFF8, 1'b1, 16'd14};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 12'hFFC, 1'b1, 16'd15};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h008, 12'h000, 1'b1, 16'd16};

        $display("[TB] start");
        doReset();

        // Cycle-by-cycle table: boot, stall, branch not taken/taken, wrap.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].branch, vecs[i].equal, vecs[i].baddr);
            checkOutput($sformatf("row%0d", i), vecs[i].exp_addr, vecs[i].exp_pc,
                        vecs[i].exp_valid, vecs[i].exp_cnt);
        end

        // Reset while stalled with a taken branch pending.
        @(negedge clk);
        rst        = 1'b1;
        Stall      = 1'b1;
        Branch     = 1'b1;
        Equal      = 1'b1;
        BranchAddr = 12'h200;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("rst0", 12'h000, 12'h000, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("rst1", 12'h004, 12'h000, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("rst2", 12'h008, 12'h000, 1'b1, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("rst3", 12'h00C, 12'h004, 1'b1, 16'd2);

        // Free-run long enough for fetch_cnt to wrap through 16'hFFFF.
        doReset();
        for (int k = 0; k <= 65538; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
            if (k == 65536) checkOutput("wrapA", 12'h000, 12'hFF8, 1'b1, 16'hFFFF);
            if (k == 65537) checkOutput("wrapB", 12'h004, 12'hFFC, 1'b1, 16'h0000);
            if (k == 65538) checkOutput("wrapC", 12'h008, 12'h000, 1'b1, 16'h0001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
